mem_port_arbiter: RTL and testbench

Responder for the CPU's two memory ports: the instruction-fetch port (A, read-only) and the data port (B, read/write with byte mask). It arbitrates both ports onto one word-wide physical memory interface, services one transaction at a time, and returns a single-cycle `resp` pulse with registered read data to the requesting port. It sits between `cpu_datapath` and the physical memory model or cache.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; a tie goes to the port not served last.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  input  logic i_served_b,
  output logic o_grant_valid,
  output logic o_grant_b
);

  port_sel_t r_last_grant;
  port_sel_t w_grant;

  // Reset to PORT_B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_B;
    end else if (i_update) begin
      r_last_grant <= i_served_b ? PORT_B : PORT_A;
    end
  end

  always_comb begin
    w_grant = PORT_A;
    if (i_req_a && i_req_b) begin
      w_grant = (r_last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (i_req_b) begin
      w_grant = PORT_B;
    end
  end

  assign o_grant_valid = i_en & (i_req_a | i_req_b);
  assign o_grant_b     = (w_grant == PORT_B);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch port (A) and data port (B) onto one physical memory
// interface, one transaction at a time, with registered responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        pmem_timeout
);

  arb_state_t r_state, w_next_state;
  port_sel_t  r_port;
  rv32i_word  r_addr, r_wdata, r_rdata_a, r_rdata_b;
  logic [3:0] r_wmask;
  logic       r_is_write, r_pmem_read, r_pmem_write;
  logic       r_resp_a, r_resp_b, r_timeout;
  logic [15:0] r_wait_cnt;
  logic [16:0] w_cnt_inc;
  logic       w_busy, w_grant_valid, w_grant_b, w_b_write;
  logic       w_unused_addr_lsbs;

  assign w_busy    = (r_state == BUSY_A) || (r_state == BUSY_B);
  assign w_cnt_inc = {1'b0, r_wait_cnt} + 17'd1;
  assign w_b_write = write;
  assign w_unused_addr_lsbs = ^{address_a[1:0], address_b[1:0]};

  rr_arbiter2 u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (r_state == IDLE),
    .i_req_a       (read_a),
    .i_req_b       (read_b | write),
    .i_update      (r_state == RESP),
    .i_served_b    (r_port == PORT_B),
    .o_grant_valid (w_grant_valid),
    .o_grant_b     (w_grant_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:           if (w_grant_valid) w_next_state = w_grant_b ? BUSY_B : BUSY_A;
      BUSY_A, BUSY_B: if (pmem_resp) w_next_state = RESP;
      RESP:           w_next_state = IDLE;
      default:        w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port       <= PORT_A;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_is_write   <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_resp_a     <= 1'b0;
      r_resp_b     <= 1'b0;
      r_wait_cnt   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_resp_a <= 1'b0;
      r_resp_b <= 1'b0;
      if (r_state == IDLE && w_grant_valid) begin
        r_port     <= w_grant_b ? PORT_B : PORT_A;
        r_wait_cnt <= '0;
        if (w_grant_b) begin
          r_addr       <= {address_b[31:2], 2'b00};
          r_wdata      <= wdata;
          r_wmask      <= wmask;
          r_is_write   <= w_b_write;
          r_pmem_read  <= ~w_b_write;
          r_pmem_write <= w_b_write;
        end else begin
          r_addr       <= {address_a[31:2], 2'b00};
          r_wdata      <= '0;
          r_wmask      <= '0;
          r_is_write   <= 1'b0;
          r_pmem_read  <= 1'b1;
          r_pmem_write <= 1'b0;
        end
      end else if (w_busy) begin
        if (r_wait_cnt != 16'hFFFF) r_wait_cnt <= w_cnt_inc[15:0];
        // Sticky: the transaction keeps waiting, only the flag reports it.
        if (32'(w_cnt_inc) >= TIMEOUT_CYCLES) r_timeout <= 1'b1;
        if (pmem_resp) begin
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
          if (r_port == PORT_A) begin
            r_resp_a  <= 1'b1;
            r_rdata_a <= pmem_rdata;
          end else begin
            r_resp_b <= 1'b1;
            if (!r_is_write) r_rdata_b <= pmem_rdata;
          end
        end
      end
    end
  end

  assign resp_a       = r_resp_a;
  assign resp_b       = r_resp_b;
  assign rdata_a      = r_rdata_a;
  assign rdata_b      = r_rdata_b;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign pmem_wmask   = r_wmask;
  assign pmem_timeout = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
  logic        pmem_timeout;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_a       (read_a),
    .address_a    (address_a),
    .resp_a       (resp_a),
    .rdata_a      (rdata_a),
    .read_b       (read_b),
    .write        (write),
    .wmask        (wmask),
    .address_b    (address_b),
    .wdata        (wdata),
    .resp_b       (resp_b),
    .rdata_b      (rdata_b),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_timeout (pmem_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".resp_a"}, 32'(resp_a), 32'd0);
    check({tag, ".resp_b"}, 32'(resp_b), 32'd0);
    check({tag, ".rdata_a"}, rdata_a, 32'd0);
    check({tag, ".rdata_b"}, rdata_b, 32'd0);
    check({tag, ".pmem_read"}, 32'(pmem_read), 32'd0);
    check({tag, ".pmem_write"}, 32'(pmem_write), 32'd0);
    check({tag, ".pmem_address"}, pmem_address, 32'd0);
    check({tag, ".pmem_wdata"}, pmem_wdata, 32'd0);
    check({tag, ".pmem_wmask"}, 32'(pmem_wmask), 32'd0);
    check({tag, ".pmem_timeout"}, 32'(pmem_timeout), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; read_a = 1'b0; address_a = '0; read_b = 1'b0; write = 1'b0;
    wmask = '0; address_b = '0; wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single A read, 3 wait cycles, response in the 4th BUSY cycle
    read_a = 1'b1; address_a = 32'h60;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("a_rd.pmem_read", 32'(pmem_read), 32'd1);
      check("a_rd.pmem_address", pmem_address, 32'h60);
      check("a_rd.resp_a_early", 32'(resp_a), 32'd0);
      tick();
    end
    check("a_rd.pmem_read4", 32'(pmem_read), 32'd1);
    check("a_rd.pmem_write", 32'(pmem_write), 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 32'h00000013;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("a_rd.resp_a", 32'(resp_a), 32'd1);
    check("a_rd.rdata_a", rdata_a, 32'h00000013);
    check("a_rd.resp_b", 32'(resp_b), 32'd0);
    check("a_rd.strobe_low", 32'(pmem_read), 32'd0);
    read_a = 1'b0;
    tick();
    check("a_rd.resp_a_one_pulse", 32'(resp_a), 32'd0);

    // B read with zero-wait memory, then B write that must keep rdata_b
    read_b = 1'b1; address_b = 32'h200;
    tick();
    check("b_rd.pmem_read", 32'(pmem_read), 32'd1);
    check("b_rd.pmem_address", pmem_address, 32'h200);
    pmem_resp = 1'b1; pmem_rdata = 32'hCAFEF00D;
    tick();
    pmem_resp = 1'b0;
    check("b_rd.resp_b", 32'(resp_b), 32'd1);
    check("b_rd.rdata_b", rdata_b, 32'hCAFEF00D);
    read_b = 1'b0;
    tick();

    write = 1'b1; address_b = 32'h102; wmask = 4'b0100; wdata = 32'h00AB0000;
    tick();
    check("b_wr.pmem_write", 32'(pmem_write), 32'd1);
    check("b_wr.pmem_read", 32'(pmem_read), 32'd0);
    check("b_wr.pmem_address", pmem_address, 32'h100);
    check("b_wr.pmem_wmask", 32'(pmem_wmask), 32'h4);
    check("b_wr.pmem_wdata", pmem_wdata, 32'h00AB0000);
    pmem_resp = 1'b1; pmem_rdata = 32'hDEADBEEF;
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("b_wr.resp_b", 32'(resp_b), 32'd1);
    check("b_wr.rdata_b_kept", rdata_b, 32'hCAFEF00D);
    check("b_wr.strobe_low", 32'(pmem_write), 32'd0);
    write = 1'b0; wmask = '0; wdata = '0;
    tick();

    // Fresh reset, then both ports held: grants alternate A, B, A, B
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    read_a = 1'b1; address_a = 32'h10; read_b = 1'b1; address_b = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tie.pmem_address", pmem_address, (i % 2 == 0) ? 32'h10 : 32'h20);
      check("tie.pmem_read", 32'(pmem_read), 32'd1);
      pmem_resp = 1'b1; pmem_rdata = 32'h1000 + 32'(i);
      tick();
      pmem_resp = 1'b0;
      check("tie.resp_a", 32'(resp_a), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("tie.resp_b", 32'(resp_b), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("tie.rdata", (i % 2 == 0) ? rdata_a : rdata_b, 32'h1000 + 32'(i));
      tick();
      check("tie.idle_strobe", 32'(pmem_read), 32'd0);
    end
    read_a = 1'b0; read_b = 1'b0;
    tick();

    // Address change during BUSY_A is ignored
    read_a = 1'b1; address_a = 32'h40;
    tick();
    address_a = 32'h80;
    check("hold.addr0", pmem_address, 32'h40);
    tick();
    check("hold.addr1", pmem_address, 32'h40);
    tick();
    check("hold.addr2", pmem_address, 32'h40);
    pmem_resp = 1'b1; pmem_rdata = 32'h77;
    tick();
    pmem_resp = 1'b0;
    check("hold.resp_a", 32'(resp_a), 32'd1);
    check("hold.rdata_a", rdata_a, 32'h77);
    read_a = 1'b0;
    tick();

    // Timeout after the 8th wait cycle, sticky past a late response
    read_b = 1'b1; address_b = 32'h300;
    tick();
    for (int i = 1; i <= 8; i++) begin
      check("to.before", 32'(pmem_timeout), 32'd0);
      tick();
    end
    check("to.set", 32'(pmem_timeout), 32'd1);
    check("to.still_busy", 32'(pmem_read), 32'd1);
    tick();
    tick();
    pmem_resp = 1'b1; pmem_rdata = 32'h55;
    tick();
    pmem_resp = 1'b0;
    check("to.late_resp_b", 32'(resp_b), 32'd1);
    check("to.late_rdata_b", rdata_b, 32'h55);
    read_b = 1'b0;
    tick();
    check("to.sticky", 32'(pmem_timeout), 32'd1);

    // Reset mid BUSY_B abandons the write; next A request is served
    write = 1'b1; address_b = 32'h104; wmask = 4'hF; wdata = 32'h12345678;
    tick();
    check("rst.busy_write", 32'(pmem_write), 32'd1);
    rst_n = 1'b0;
    write = 1'b0;
    #1;
    check_all_zero("rst_mid");
    #3;
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("rst.no_resp_b", 32'(resp_b), 32'd0);
    check("rst.idle_write", 32'(pmem_write), 32'd0);
    check("rst.idle_read", 32'(pmem_read), 32'd0);
    read_a = 1'b1; address_a = 32'h8;
    tick();
    check("rst.a_read", 32'(pmem_read), 32'd1);
    check("rst.a_addr", pmem_address, 32'h8);
    pmem_resp = 1'b1; pmem_rdata = 32'h99;
    tick();
    pmem_resp = 1'b0;
    check("rst.a_resp", 32'(resp_a), 32'd1);
    check("rst.a_rdata", rdata_a, 32'h99);
    check("rst.a_no_resp_b", 32'(resp_b), 32'd0);
    read_a = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
